// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / 32/32 divide with architectural
// HI/LO registers. One result bit per cycle, 32 cycles per operation, result
// committed to HI/LO on the final iteration together with a one-cycle done.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;        // {upper, lower}: product or {remainder, quotient}
  logic [31:0] b_q, b_d;            // |multiplicand| or |divisor|
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] rs_q, rs_d;          // original dividend, reported as HI on divide-by-zero
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh, div_diff;
  logic [63:0] div_next;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes and one iteration of shift-add / restoring divide.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && RsData[31]) ? (32'd0 - RsData) : RsData;
    b_mag     = (signed_op && RtData[31]) ? (32'd0 - RtData) : RtData;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole thing right.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Divide: shift the next dividend bit into the remainder and subtract the
    // divisor; keep the difference only if it did not borrow.
    rem_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = rem_sh - {1'b0, b_q};
    div_next = div_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                            : {div_diff[31:0], acc_q[30:0], 1'b1};

    step     = is_div_q ? div_next : mul_next;
    prod_fix = neg_res_q ? (64'd0 - step) : step;
    quo_fix  = neg_res_q ? (32'd0 - step[31:0]) : step[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - step[63:32]) : step[63:32];
  end

  // Next-state logic: launch, iterate, commit, and MTHI/MTLO writes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    rs_d      = rs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d   = S_RUN;
        cnt_d     = 6'd0;
        acc_d     = {32'd0, a_mag};
        b_d       = b_mag;
        is_div_d  = op[1];
        neg_res_d = signed_op & (RsData[31] ^ RtData[31]);
        neg_rem_d = signed_op & RsData[31];
        rs_d      = RsData;
      end else begin
        if (hi_we) hi_d = RsData;
        if (lo_we) lo_d = RsData;
      end
    end else begin
      acc_d = step;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd31) begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (b_q == 32'd0) begin
          hi_d = rs_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
    end
  end

  // State registers; reset aborts any operation in flight without committing.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here is a plain flop (no memory array), so all of them are reset; the datapath too, to keep an aborted run from leaving stale state.
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      b_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rs_q      <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values, whatever the statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      rs_q      <= rs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q == S_RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a reference model pushes expected
// {HI, LO} into a scoreboard at launch; the entry is popped on done.
module tb_mul_div_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;

  res_t        sb_q[$];
  logic [31:0] exp_hi, exp_lo;
  int          n_vec;
  int          n_bad;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .RsData (RsData),
    .RtData (RtData),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model built on the simulator's own 64-bit arithmetic.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0]        up;
    res_t               res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    res = '0;
    case (o)
      2'b00: begin p = sa * sb; res.hi = p[63:32]; res.lo = p[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; res.hi = up[63:32]; res.lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res.hi = r[31:0];
          res.lo = q[31:0];
        end else begin
          res.hi = a % b;
          res.lo = a / b;
        end
      end
    endcase
    return res;
  endfunction

  // Launch one operation at the current negedge and follow it to done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit perturb, input bit we_too);
    int   cycles;
    res_t r;
    start  = 1'b1;
    op     = o;
    RsData = a;
    RtData = b;
    hi_we  = we_too;
    lo_we  = we_too;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    RsData = $urandom;
    RtData = $urandom;
    check("done_low_in_run", {63'd0, done}, 64'd0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      check("hi_hold", {32'd0, hi_out}, {32'd0, exp_hi});
      check("lo_hold", {32'd0, lo_out}, {32'd0, exp_lo});
      if (perturb && cycles == 5) begin
        start = 1'b1;
        op    = ~o;
        hi_we = 1'b1;
        lo_we = 1'b1;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("busy_cycles", 64'(cycles), 64'd32);
    check("done_pulse", {63'd0, done}, 64'd1);
    r = sb_q.pop_front();
    check("hi_result", {32'd0, hi_out}, {32'd0, r.hi});
    check("lo_result", {32'd0, lo_out}, {32'd0, r.lo});
    exp_hi = r.hi;
    exp_lo = r.lo;
  endtask

  // MTHI/MTLO from IDLE, one edge of latency.
  task automatic move_to(input bit wh, input bit wl, input logic [31:0] v);
    hi_we  = wh;
    lo_we  = wl;
    RsData = v;
    @(negedge clk);
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    RsData = $urandom;
    if (wh) exp_hi = v;
    if (wl) exp_lo = v;
    check("mt_hi", {32'd0, hi_out}, {32'd0, exp_hi});
    check("mt_lo", {32'd0, lo_out}, {32'd0, exp_lo});
    check("mt_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    clk    = 1'b0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    RsData = 32'd0;
    RtData = 32'd0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    n_vec  = 0;
    n_bad  = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    #1;
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Multiplies; MULTU then MULT back-to-back (second start in the done cycle).
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Divides, including the signed overflow wrap and divide-by-zero.
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Start/writes while busy are ignored; start beats writes in IDLE.
    @(negedge clk);
    do_op(2'b01, 32'h0001_2345, 32'h0006_789A, 1'b1, 1'b0);
    @(negedge clk);
    do_op(2'b11, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b1);

    // MTHI/MTLO.
    @(negedge clk);
    move_to(1'b1, 1'b1, 32'hA5A5_A5A5);
    move_to(1'b1, 1'b0, 32'h1111_2222);
    move_to(1'b0, 1'b1, 32'h3333_4444);

    // Random operations.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      do_op(ro, ra, rb, 1'b0, 1'b0);
    end

    // Reset in the middle of a MULT aborts with no commit.
    @(negedge clk);
    start  = 1'b1;
    op     = 2'b00;
    RsData = 32'h7FFF_0001;
    RtData = 32'h0000_0123;
    @(negedge clk);
    start  = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_hi", {32'd0, hi_out}, 64'd0);
    check("abort_lo", {32'd0, lo_out}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_abort_hi", {32'd0, hi_out}, 64'd0);
    check("post_abort_lo", {32'd0, lo_out}, 64'd0);
    check("post_abort_done", {63'd0, done}, 64'd0);
    do_op(2'b11, 32'd9, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits directly downstream of the register file and consumes its two read-port outputs (Rs/Rt data) for MULT, MULTU, DIV and DIVU. It also handles MTHI/MTLO writes and presents HI/LO for MFHI/MFLO. While busy it raises `busy`, which the controller uses to stall the PC.

## Interface
Parameters:
- none; datapath fixed at 32 bits, 32 iterations.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  launch operation selected by `op`; sampled only when idle.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `RsData`  in  32  operand A / dividend, from register file Rs port.
- `RtData`  in  32  operand B / divisor, from register file Rt port.
- `hi_we`  in  1  MTHI: write `RsData` into HI.
- `lo_we`  in  1  MTLO: write `RsData` into LO.
- `hi_out`  out  32  current HI.
- `lo_out`  out  32  current LO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: result just committed to HI/LO.

## Operation
- States: IDLE, RUN (32 iterations), and an implicit DONE cycle flagged by `done`.
- IDLE + `start`=1: capture operands and op, clear iteration counter (6 bits), go to RUN. For signed ops, capture magnitudes |Rs|, |Rt| and two flags. Result sign: Rs[31]^Rt[31]. Remainder sign: Rs[31].
- RUN, multiply: radix-2 shift-add on a 64-bit accumulator, unsigned magnitudes. One multiplier bit per cycle.
- RUN, divide: radix-2 restoring division on a 64-bit {remainder, quotient} register. One quotient bit per cycle.
- Final iteration (counter = 31): apply sign correction (two's-complement negate) and commit:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Return to IDLE.
- Divide by zero (Rt = 0), DIV or DIVU: full 32-cycle latency, then LO = 32'hFFFF_FFFF, HI = original RsData.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This is the natural wrap; no trap.
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0; take effect at the next edge.
  - Both asserted together: both HI and LO get RsData.
  - `start` and `hi_we`/`lo_we` together in IDLE: `start` wins, writes ignored.
- While busy: `start`, `hi_we`, `lo_we` ignored. Operands are latched at start, so RsData/RtData may change freely during RUN.
- `hi_out`/`lo_out` show the committed HI/LO only. Intermediate accumulator values are never visible.

## Timing
- Reset (asynchronous, `reset`=0): HI=0, LO=0, `busy`=0, `done`=0, state IDLE, counter 0.
  - Reset mid-RUN aborts the operation with no partial commit.
  - Release is synchronous to the next `clk` edge in normal use.
- `start` sampled at edge E0. `busy`=1 from after E0 through the edge E32 where HI/LO commit, i.e. exactly 32 cycles high.
- After E32: `busy`=0, `done`=1 for exactly one cycle, new HI/LO visible.
- A new `start` may be sampled at E33, the same cycle `done` is high, giving back-to-back operations every 33 cycles.
- MTHI/MTLO latency: 1 edge. MFHI/MFLO read `hi_out`/`lo_out` combinationally with zero latency.
- No combinational path from inputs to `busy`/`done`; both are registered.

## Test plan
- MULT, Rs=0xFFFF_FFFD (−3), Rt=5 -> `busy` high 32 cycles, then `done` pulse with HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
- MULTU, Rs=Rt=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001. Then MULT with the same operands -> HI=0, LO=1.
- DIV −7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x8000_0000/−1 -> LO=0x8000_0000, HI=0.
- DIVU 0x1234_5678 / 0 -> after 32 cycles LO=0xFFFF_FFFF, HI=0x1234_5678.
- During RUN, pulse `start` with a different op plus `hi_we`, `lo_we` -> all ignored, original result committed. In IDLE, `hi_we`=`lo_we`=1 with RsData=0xA5A5_A5A5 -> both HI and LO = 0xA5A5_A5A5 next cycle.
- Start MULT, assert `reset`=0 at iteration 10 -> HI=LO=0, `busy`=0 immediately. After release, a fresh DIVU 9/3 gives LO=3, HI=0.
